mdu_ctrl: RTL and testbench

//  Multiply/divide unit controller owning the HI/LO register pair for the MIPS EX stage.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_if.sv | 32 +++
 rtl/mdu_div_step.sv | 25 ++
 rtl/mdu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared types: operation codes, controller states,
// divide iteration count and an operation-class helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

  localparam int DIV_ITERS = 32;

  // Operations that occupy the unit and freeze the pipeline.
  function automatic logic is_arith(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Optional macro MDU_CANCEL_EN adds the cancel request line.
interface mdu_if #(
  parameter int DW = 32
);
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
`ifdef MDU_CANCEL_EN
  logic          cancel;
`endif
  logic          stall;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

`ifdef MDU_CANCEL_EN
  modport master (output start, op, a, b, cancel,
                  input  stall, busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, cancel,
                  output stall, busy, done, div_by_zero, hi, lo);
`else
  modport master (output start, op, a, b,
                  input  stall, busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b,
                  output stall, busy, done, div_by_zero, hi, lo);
`endif

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_in,
  input  logic [DW-1:0] divisor,
  input  logic          dvd_bit,
  output logic [DW-1:0] rem_out,
  output logic          q_bit
);

  logic [DW:0] trial;
  logic [DW:0] diff;

  // Remainder stays below the divisor, so the trial fits in DW+1 bits and
  // the borrow (diff MSB) alone decides the quotient bit.
  always_comb begin
    trial   = {rem_in, dvd_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[DW];
    rem_out = q_bit ? diff[DW-1:0] : trial[DW-1:0];
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning HI/LO for the EX stage.
// Optional macro MDU_CANCEL_EN enables aborting an in-flight operation.
//
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO execute here
//   MUL    | product settling, done in the last MUL cycle
//   DIV    | one restoring quotient bit per cycle, counter 31..0
//   FIX    | apply result signs (or divide-by-zero values), done
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = 1
) (
  input logic  clk,
  input logic  resetn,
  mdu_if.slave bus
);

  mdu_state_e      state, state_nx;
  mdu_op_e         op_e;
  logic [4:0]      cnt;
  logic [DW-1:0]   op_a, op_b, rem;
  logic            sa, sb, dbz_r;
  logic [DW-1:0]   hi_r, lo_r;
  logic            cancel_w, busy, is_signed;
  logic [DW-1:0]   a_mag, b_mag;
  logic [2*DW-1:0] prod_mag, prod_res;
  logic [DW-1:0]   step_rem;
  logic            step_q;
  logic            acc_mul, acc_div, acc_dbz, wr_hi, wr_lo;
  logic            mul_fin, fix_fin, done_c, dbz_c;

  assign op_e = mdu_op_e'(bus.op);

`ifdef MDU_CANCEL_EN
  assign cancel_w = bus.cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign a_mag     = (is_signed && bus.a[DW-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[DW-1]) ? -bus.b : bus.b;
  assign prod_mag  = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
  assign prod_res  = (sa ^ sb) ? -prod_mag : prod_mag;

  div_step #(.DW(DW)) u_div_step (
    .rem_in  (rem),
    .divisor (op_b),
    .dvd_bit (op_a[DW-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    acc_mul  = 1'b0;
    acc_div  = 1'b0;
    acc_dbz  = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    mul_fin  = 1'b0;
    fix_fin  = 1'b0;
    done_c   = 1'b0;
    dbz_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !cancel_w) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              acc_mul  = 1'b1;
              state_nx = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.b == '0) begin
                acc_dbz  = 1'b1;
                state_nx = S_FIX;
              end else begin
                acc_div  = 1'b1;
                state_nx = S_DIV;
              end
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel_w) state_nx = S_IDLE;
        else if (cnt == '0) begin
          mul_fin  = 1'b1;
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_DIV: begin
        if (cancel_w)        state_nx = S_IDLE;
        else if (cnt == '0) state_nx = S_FIX;
      end
      S_FIX: begin
        if (cancel_w) state_nx = S_IDLE;
        else begin
          fix_fin  = 1'b1;
          done_c   = 1'b1;
          dbz_c    = dbz_r;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy            = (state != S_IDLE);
  assign bus.busy        = busy;
  assign bus.done        = done_c;
  assign bus.div_by_zero = dbz_c;
  assign bus.stall       = acc_mul | acc_div | acc_dbz | (busy & ~done_c);
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

  // Operand magnitudes, signs, iteration counter and divide shift registers.
  // A zero divisor preloads the FIX inputs so FIX needs no special case.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      rem   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dbz_r <= 1'b0;
    end else begin
      if (acc_mul || acc_div) begin
        op_a  <= a_mag;
        op_b  <= b_mag;
        sa    <= is_signed & bus.a[DW-1];
        sb    <= is_signed & bus.b[DW-1];
        rem   <= '0;
        dbz_r <= 1'b0;
        cnt   <= acc_mul ? 5'(MUL_CYCLES - 1) : 5'(DIV_ITERS - 1);
      end else if (acc_dbz) begin
        op_a  <= '1;
        rem   <= bus.a;
        sa    <= 1'b0;
        sb    <= 1'b0;
        dbz_r <= 1'b1;
        cnt   <= '0;
      end else if (state == S_MUL && cnt != '0) begin
        cnt <= cnt - 5'd1;
      end else if (state == S_DIV && !cancel_w) begin
        rem  <= step_rem;
        op_a <= {op_a[DW-2:0], step_q};
        if (cnt != '0) cnt <= cnt - 5'd1;
      end
    end
  end

  // Architectural HI/LO: moves, product write-back and signed divide results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (wr_hi) begin
      hi_r <= bus.a;
    end else if (wr_lo) begin
      lo_r <= bus.a;
    end else if (mul_fin) begin
      {hi_r, lo_r} <= prod_res;
    end else if (fix_fin) begin
      lo_r <= (sa ^ sb) ? -op_a : op_a;
      hi_r <= sa ? -rem : rem;
    end
  end

  // A new request while an operation is in flight is a protocol error.
  a_no_start_busy: assert property (@(posedge clk) disable iff (!resetn) !(bus.start && busy))
    else $error("mdu_ctrl: start asserted while busy");

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: table of operations with expected HI/LO, stall length
// and latency, pushed to a scoreboard on issue and popped on completion,
// plus hand sequences for moves, illegal ops, reset and (MDU_CANCEL_EN) cancel.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MUL_C = 1;
  localparam int NV    = 22;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          estall;
    int          elat;
  } vec_t;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  vec_t tbl[NV];
  vec_t sbq[$];

  mdu_if #(.DW(32)) bus ();

  mdu_ctrl #(.DW(32), .MUL_CYCLES(MUL_C)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                               input int estall, input int elat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo;
    v.edbz = edbz; v.estall = estall; v.elat = elat;
    return v;
  endfunction

  // Reference results from native 64-bit arithmetic (arith ops only).
  function automatic vec_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    logic signed [63:0] sa64, sb64, sq, sr;
    logic [63:0] ua, ub, up;
    v = mkv(op, a, b, 32'h0, 32'h0, 1'b0, 0, 0);
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    case (op)
      3'd0: begin up = sa64 * sb64; v.ehi = up[63:32]; v.elo = up[31:0]; v.estall = MUL_C; v.elat = MUL_C; end
      3'd1: begin up = ua * ub;     v.ehi = up[63:32]; v.elo = up[31:0]; v.estall = MUL_C; v.elat = MUL_C; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          v.ehi = a; v.elo = 32'hFFFF_FFFF; v.edbz = 1'b1; v.estall = 1; v.elat = 1;
        end else begin
          if (op == 3'd2) begin
            sq = sa64 / sb64; sr = sa64 % sb64;
            v.elo = sq[31:0]; v.ehi = sr[31:0];
          end else begin
            up = ua / ub; v.elo = up[31:0];
            up = ua % ub; v.ehi = up[31:0];
          end
          v.estall = 33; v.elat = 33;
        end
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int stall_cnt, lat;
    logic got, dbz_seen;
    logic [31:0] hi0, lo0, hid, lod;
    @(negedge clk);
    bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
    sbq.push_back(v);
    #1;
    stall_cnt = bus.stall ? 1 : 0;
    hi0 = bus.hi; lo0 = bus.lo;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e = sbq.pop_front();
    lat = 0; got = 1'b0; dbz_seen = 1'b0; hid = hi0; lod = lo0;
    if (e.elat != 0) begin
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (bus.stall) stall_cnt++;
        if (bus.done) begin
          lat = k; got = 1'b1; dbz_seen = bus.div_by_zero; hid = bus.hi; lod = bus.lo;
          break;
        end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL %s_timeout no done within 100 cycles", tag);
      end
      @(posedge clk); #1;
      chk({tag, "_lat"}, lat, e.elat);
      chk({tag, "_dbz"}, {31'd0, dbz_seen}, {31'd0, e.edbz});
      chk({tag, "_hi_at_done"}, hid, hi0);
      chk({tag, "_lo_at_done"}, lod, lo0);
    end
    chk({tag, "_stall"}, stall_cnt, e.estall);
    chk({tag, "_hi"}, bus.hi, e.ehi);
    chk({tag, "_lo"}, bus.lo, e.elo);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b0;
`endif

    tbl[0]  = mkv(OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MUL_C, MUL_C);
    tbl[1]  = mkv(OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 33, 33);
    tbl[2]  = mkv(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33);
    tbl[3]  = mkv(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 33, 33);
    tbl[4]  = mkv(OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 1, 1);
    tbl[5]  = mkv(OP_DIV,   32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 1, 1);
    tbl[6]  = mkv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_C, MUL_C);
    tbl[7]  = mkv(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0, MUL_C, MUL_C);
    tbl[8]  = mkv(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 33, 33);
    tbl[9]  = mkv(OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, 33, 33);
    tbl[10] = mkv(OP_DIVU,  32'd3,         32'd7,        32'd3,         32'd0,         1'b0, 33, 33);
    tbl[11] = mkv(OP_MTHI,  32'hCAFE_BABE, 32'd0,        32'hCAFE_BABE, 32'd0,         1'b0, 0, 0);
    tbl[12] = mkv(OP_MTLO,  32'h0BAD_F00D, 32'd0,        32'hCAFE_BABE, 32'h0BAD_F00D, 1'b0, 0, 0);
    tbl[13] = mkv(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         1'b0, MUL_C, MUL_C);
    for (int i = 14; i < NV; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      tbl[i] = model(rop, ra, rb);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, bus.busy},        32'd0);
    chk("rst_stall", {31'd0, bus.stall},       32'd0);
    chk("rst_done",  {31'd0, bus.done},        32'd0);
    chk("rst_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
    chk("rst_hi",    bus.hi, 32'd0);
    chk("rst_lo",    bus.lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Back-to-back MTHI / MTLO
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1234_5678;
    #1 chk("mt_stall0", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.op = OP_MTLO; bus.a = 32'h9ABC_DEF0;
    chk("mt_hi1", bus.hi, 32'h1234_5678);
    @(negedge clk);
    chk("mt_stall1", {31'd0, bus.stall}, 32'd0);
    chk("mt_busy1",  {31'd0, bus.busy},  32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mt_hi2", bus.hi, 32'h1234_5678);
    chk("mt_lo2", bus.lo, 32'h9ABC_DEF0);

    // Illegal op codes are ignored
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'(k); bus.a = 32'h5555_5555; bus.b = 32'd1;
      #1 chk($sformatf("ill%0d_stall", k), {31'd0, bus.stall}, 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk($sformatf("ill%0d_busy", k), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("ill%0d_hi", k), bus.hi, 32'h1234_5678);
      chk($sformatf("ill%0d_lo", k), bus.lo, 32'h9ABC_DEF0);
    end

`ifdef MDU_CANCEL_EN
    // Cancel at iteration 10 of a divide keeps HI/LO and yields no done
    begin
      int dn;
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.cancel = 1'b1;
      #1 chk("can_done", {31'd0, bus.done}, 32'd0);
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      chk("can_busy", {31'd0, bus.busy}, 32'd0);
      chk("can_hi", bus.hi, 32'h1234_5678);
      chk("can_lo", bus.lo, 32'h9ABC_DEF0);
      dn = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus.done) dn++;
      end
      chk("can_no_done", dn, 32'd0);
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULT; bus.a = 32'd2; bus.b = 32'd3;
      #1 chk("can_start_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      chk("can_start_busy", {31'd0, bus.busy}, 32'd0);
      run_vec(mkv(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, MUL_C, MUL_C), "post_can");
    end
`endif

    // Reset asserted at iteration 10 of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("mrst_busy",  {31'd0, bus.busy},  32'd0);
    chk("mrst_stall", {31'd0, bus.stall}, 32'd0);
    chk("mrst_done",  {31'd0, bus.done},  32'd0);
    chk("mrst_hi", bus.hi, 32'd0);
    chk("mrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("mrst_idle", {31'd0, bus.busy}, 32'd0);
    run_vec(tbl[1], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
